// File: rtl/ucsbece154a_prog_loader_pkg.sv
// Shared definitions for the program loader.
// Kind codes for I/S/B/J/U reuse the core's ImmSrc encoding so the loader's
// format field reads the same as the decoder's immediate-source select.
// R and END take the free codes; 3'b110 stays reserved and is rejected.
package ucsbece154a_prog_loader_pkg;

  localparam logic [2:0] KIND_I   = 3'b000;
  localparam logic [2:0] KIND_S   = 3'b001;
  localparam logic [2:0] KIND_B   = 3'b010;
  localparam logic [2:0] KIND_J   = 3'b011;
  localparam logic [2:0] KIND_U   = 3'b100;
  localparam logic [2:0] KIND_R   = 3'b101;
  localparam logic [2:0] KIND_END = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_WRITE,
    S_DONE,
    S_ERR
  } state_t;

endpackage

// File: rtl/ucsbece154a_instr_pack.sv
// Combinational RV32I instruction packer with immediate range/alignment check.
// Ports:
//   kind_i      format code (I/S/B/J/U/R/END, 110 reserved)
//   op_i        opcode, placed verbatim in [6:0]
//   funct3_i    funct3 for R/I/S/B
//   funct7b5_i  instr[30] for R-type
//   rd_i, rs1_i, rs2_i  register fields, used per format
//   imm_i       signed byte immediate (U uses [31:12])
//   word_o      packed instruction word
//   illegal_o   beat cannot be encoded (reserved kind or bad immediate)
module ucsbece154a_instr_pack
  import ucsbece154a_prog_loader_pkg::*;
(
  input  logic [2:0]  kind_i,
  input  logic [6:0]  op_i,
  input  logic [2:0]  funct3_i,
  input  logic        funct7b5_i,
  input  logic [4:0]  rd_i,
  input  logic [4:0]  rs1_i,
  input  logic [4:0]  rs2_i,
  input  logic [31:0] imm_i,
  output logic [31:0] word_o,
  output logic        illegal_o
);

  logic signed [31:0] simm;
  logic               fits_12;
  logic               fits_b;
  logic               fits_j;

  assign simm    = $signed(imm_i);
  assign fits_12 = (simm >= -32'sd2048) && (simm <= 32'sd2047);
  // Branch/jump offsets are in bytes; bit 0 is not encodable.
  assign fits_b  = (simm >= -32'sd4096) && (simm <= 32'sd4094) && !imm_i[0];
  assign fits_j  = (simm >= -32'sd1048576) && (simm <= 32'sd1048574) && !imm_i[0];

  always_comb begin
    word_o    = '0;
    illegal_o = 1'b0;
    case (kind_i)
      KIND_I: begin
        word_o    = {imm_i[11:0], rs1_i, funct3_i, rd_i, op_i};
        illegal_o = !fits_12;
      end
      KIND_S: begin
        word_o    = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], op_i};
        illegal_o = !fits_12;
      end
      KIND_B: begin
        word_o    = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                     imm_i[4:1], imm_i[11], op_i};
        illegal_o = !fits_b;
      end
      KIND_J: begin
        word_o    = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, op_i};
        illegal_o = !fits_j;
      end
      KIND_U: begin
        word_o    = {imm_i[31:12], rd_i, op_i};
      end
      KIND_R: begin
        word_o    = {1'b0, funct7b5_i, 5'b0, rs2_i, rs1_i, funct3_i, rd_i, op_i};
      end
      KIND_END: begin
        word_o    = '0;
      end
      default: begin
        illegal_o = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/ucsbece154a_prog_loader.sv
// Instruction-memory loader: accepts field-level instruction beats over a
// valid/ready stream, packs them into RV32I words, writes them to consecutive
// word addresses and holds the core in reset until an END beat completes the
// session.
// Ports:
//   clk, reset         clock, synchronous active-high reset
//   start_i            begin a session (honoured in IDLE/DONE/ERR)
//   valid_i / ready_o  beat handshake
//   kind_i .. imm_i    instruction fields
//   imem_we_o/addr_o/wd_o  instruction-memory write port
//   core_reset_o       core held in reset while not DONE
//   count_o            words written this session
//   done_o, err_o      session completed / aborted
module ucsbece154a_prog_loader
  import ucsbece154a_prog_loader_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start_i,
  input  logic                  valid_i,
  output logic                  ready_o,
  input  logic [2:0]            kind_i,
  input  logic [6:0]            op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  funct7b5_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [31:0]           imm_i,
  output logic                  imem_we_o,
  output logic [ADDR_WIDTH-1:0] imem_addr_o,
  output logic [31:0]           imem_wd_o,
  output logic                  core_reset_o,
  output logic [ADDR_WIDTH:0]   count_o,
  output logic                  done_o,
  output logic                  err_o
);

  localparam logic [ADDR_WIDTH:0] CAPACITY = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t              state_q, state_d;
  logic [ADDR_WIDTH:0] count_q, count_d;
  logic [31:0]         word_q, word_d;

  logic [31:0]         pack_word;
  logic                pack_illegal;
  logic                full;

  ucsbece154a_instr_pack u_pack (
    .kind_i     (kind_i),
    .op_i       (op_i),
    .funct3_i   (funct3_i),
    .funct7b5_i (funct7b5_i),
    .rd_i       (rd_i),
    .rs1_i      (rs1_i),
    .rs2_i      (rs2_i),
    .imm_i      (imm_i),
    .word_o     (pack_word),
    .illegal_o  (pack_illegal)
  );

  assign full = (count_q == CAPACITY);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      count_q <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      word_q  <= word_d;
    end
  end

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    word_d  = word_q;
    case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (start_i) begin
          state_d = S_LOAD;
          count_d = '0;
        end
      end
      S_LOAD: begin
        if (valid_i) begin
          // END is accepted even when the memory is full.
          if (kind_i == KIND_END) begin
            state_d = S_DONE;
          end else if (pack_illegal || full) begin
            state_d = S_ERR;
          end else begin
            word_d  = pack_word;
            state_d = S_WRITE;
          end
        end
      end
      S_WRITE: begin
        count_d = count_q + 1'b1;
        state_d = S_LOAD;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs come only from registered state, never straight from inputs.
  assign ready_o      = (state_q == S_LOAD);
  assign imem_we_o    = (state_q == S_WRITE);
  assign imem_addr_o  = count_q[ADDR_WIDTH-1:0];
  assign imem_wd_o    = word_q;
  assign core_reset_o = (state_q != S_DONE);
  assign count_o      = count_q;
  assign done_o       = (state_q == S_DONE);
  assign err_o        = (state_q == S_ERR);

endmodule

// File: tb/tb_ucsbece154a_prog_loader.sv
module tb_ucsbece154a_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start_a = 1'b0, valid_a = 1'b0;
  logic        start_b = 1'b0, valid_b = 1'b0;
  logic [2:0]  kind = '0;
  logic [6:0]  op = '0;
  logic [2:0]  f3 = '0;
  logic        f7b5 = 1'b0;
  logic [4:0]  rd = '0, rs1 = '0, rs2 = '0;
  logic [31:0] imm = '0;

  logic        rdy_a, we_a, crst_a, done_a, err_a;
  logic [5:0]  addr_a;
  logic [31:0] wd_a;
  logic [6:0]  cnt_a;
  logic        rdy_b, we_b, crst_b, done_b, err_b;
  logic [1:0]  addr_b;
  logic [31:0] wd_b;
  logic [2:0]  cnt_b;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct { int addr; logic [31:0] data; } wr_t;
  wr_t qa[$];
  wr_t qb[$];

  always #5 clk = ~clk;

  ucsbece154a_prog_loader #(.ADDR_WIDTH(6)) dut_a (
    .clk(clk), .reset(reset), .start_i(start_a), .valid_i(valid_a), .ready_o(rdy_a),
    .kind_i(kind), .op_i(op), .funct3_i(f3), .funct7b5_i(f7b5),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .imem_we_o(we_a), .imem_addr_o(addr_a), .imem_wd_o(wd_a),
    .core_reset_o(crst_a), .count_o(cnt_a), .done_o(done_a), .err_o(err_a)
  );

  ucsbece154a_prog_loader #(.ADDR_WIDTH(2)) dut_b (
    .clk(clk), .reset(reset), .start_i(start_b), .valid_i(valid_b), .ready_o(rdy_b),
    .kind_i(kind), .op_i(op), .funct3_i(f3), .funct7b5_i(f7b5),
    .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .imm_i(imm),
    .imem_we_o(we_b), .imem_addr_o(addr_b), .imem_wd_o(wd_b),
    .core_reset_o(crst_b), .count_o(cnt_b), .done_o(done_b), .err_o(err_b)
  );

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Write monitors: every write strobe must match the head of its queue.
  always @(negedge clk) begin
    if (we_a === 1'b1) begin
      if (qa.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL a_unexpected_write: got addr %0d data %h, expected no write", addr_a, wd_a);
      end else begin
        wr_t w;
        w = qa.pop_front();
        chk("a_wr_addr", 64'(addr_a), 64'(w.addr));
        chk("a_wr_data", 64'(wd_a), 64'(w.data));
      end
    end
  end

  always @(negedge clk) begin
    if (we_b === 1'b1) begin
      if (qb.size() == 0) begin
        n_cmp++; n_err++;
        $display("FAIL b_unexpected_write: got addr %0d data %h, expected no write", addr_b, wd_b);
      end else begin
        wr_t w;
        w = qb.pop_front();
        chk("b_wr_addr", 64'(addr_b), 64'(w.addr));
        chk("b_wr_data", 64'(wd_b), 64'(w.data));
      end
    end
  end

  // Present one beat to DUT sel (0=a, 1=b); returns #1 after the accepting edge.
  task automatic send(input bit sel, input logic [2:0] k, input logic [6:0] o,
                      input logic [2:0] fn3, input logic f7, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [31:0] im,
                      input bit exp_wr, input int ea, input logic [31:0] ed);
    int t;
    if (exp_wr) begin
      wr_t w;
      w.addr = ea;
      w.data = ed;
      if (sel) qb.push_back(w); else qa.push_back(w);
    end
    @(negedge clk);
    kind = k; op = o; f3 = fn3; f7b5 = f7; rd = d; rs1 = s1; rs2 = s2; imm = im;
    if (sel) valid_b = 1'b1; else valid_a = 1'b1;
    t = 0;
    while (((sel ? rdy_b : rdy_a) !== 1'b1) && t < 20) begin
      @(negedge clk);
      t++;
    end
    if (t >= 20) begin
      n_cmp++; n_err++;
      $display("FAIL ready_timeout: got ready low for %0d cycles, expected high", t);
    end
    @(posedge clk);
    #1;
    valid_a = 1'b0;
    valid_b = 1'b0;
  endtask

  task automatic pulse_start(input bit sel);
    @(negedge clk);
    if (sel) start_b = 1'b1; else start_a = 1'b1;
    @(posedge clk);
    #1;
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  task automatic chk_reset_a(input string tag);
    chk({tag, "_ready"}, 64'(rdy_a), 64'd0);
    chk({tag, "_we"},    64'(we_a),  64'd0);
    chk({tag, "_addr"},  64'(addr_a), 64'd0);
    chk({tag, "_wd"},    64'(wd_a),  64'd0);
    chk({tag, "_crst"},  64'(crst_a), 64'd1);
    chk({tag, "_count"}, 64'(cnt_a), 64'd0);
    chk({tag, "_done"},  64'(done_a), 64'd0);
    chk({tag, "_err"},   64'(err_a), 64'd0);
  endtask

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_S  = 7'b0100011;
  localparam logic [6:0] OP_B  = 7'b1100011;
  localparam logic [6:0] OP_J  = 7'b1101111;
  localparam logic [6:0] OP_U  = 7'b0110111;

  initial begin
    #2000000;
    $display("FAIL watchdog: got no completion, expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk_reset_a("rst");
    reset = 1'b0;
    @(posedge clk); #1;
    chk_reset_a("idle");

    // Session 1: add / sub (imm holds junk that R-type must ignore).
    pulse_start(0);
    chk("s1_ready", 64'(rdy_a), 64'd1);
    send(0, 3'b101, OP_R, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'hDEADBEEF, 1, 0, 32'h002081B3);
    chk("add_ready_low", 64'(rdy_a), 64'd0);
    chk("add_we_high",   64'(we_a),  64'd1);
    send(0, 3'b101, OP_R, 3'b000, 1'b1, 5'd3, 5'd1, 5'd2, 32'h00000000, 1, 1, 32'h402081B3);
    chk("sub_ready_low", 64'(rdy_a), 64'd0);
    send(0, 3'b111, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 32'd0);
    chk("s1_done",  64'(done_a), 64'd1);
    chk("s1_count", 64'(cnt_a),  64'd2);

    // Session 2: branch/jump/upper, then END.
    pulse_start(0);
    chk("s2_crst_reasserted", 64'(crst_a), 64'd1);
    chk("s2_count_cleared",   64'(cnt_a),  64'd0);
    chk("s2_done_cleared",    64'(done_a), 64'd0);
    send(0, 3'b010, OP_B, 3'b000, 1'b1, 5'd31, 5'd1, 5'd2, 32'hFFFFFFF8, 1, 0, 32'hFE208CE3);
    send(0, 3'b011, OP_J, 3'b111, 1'b1, 5'd0, 5'd9, 5'd9, 32'd0, 1, 1, 32'h0000006F);
    send(0, 3'b100, OP_U, 3'b101, 1'b0, 5'd5, 5'd7, 5'd7, 32'h12345ABC, 1, 2, 32'h123452B7);
    @(posedge clk); #1;
    chk("s2_crst_before_end", 64'(crst_a), 64'd1);
    send(0, 3'b111, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 32'd0);
    chk("s2_crst_dropped", 64'(crst_a), 64'd0);
    chk("s2_done",         64'(done_a), 64'd1);
    chk("s2_count",        64'(cnt_a),  64'd3);

    // Illegal beats: no write, core stays in reset.
    pulse_start(0);
    send(0, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2048, 0, 0, 32'd0);
    chk("i2048_err",  64'(err_a),  64'd1);
    chk("i2048_crst", 64'(crst_a), 64'd1);
    chk("i2048_done", 64'(done_a), 64'd0);
    pulse_start(0);
    chk("err_cleared", 64'(err_a), 64'd0);
    send(0, 3'b010, OP_B, 3'b000, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3, 0, 0, 32'd0);
    chk("b_odd_err",  64'(err_a),  64'd1);
    chk("b_odd_crst", 64'(crst_a), 64'd1);
    pulse_start(0);
    send(0, 3'b110, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd0, 0, 0, 32'd0);
    chk("k110_err",  64'(err_a),  64'd1);
    chk("k110_crst", 64'(crst_a), 64'd1);

    // Boundary immediates, then reset in a WRITE cycle.
    pulse_start(0);
    send(0, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800, 1, 0, 32'h80000093);
    send(0, 3'b001, OP_S, 3'b010, 1'b0, 5'd9, 5'd1, 5'd2, 32'd2047, 1, 1, 32'h7E20AFA3);
    send(0, 3'b101, OP_R, 3'b000, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0, 1, 2, 32'h002081B3);
    chk("pre_reset_we", 64'(we_a), 64'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    chk_reset_a("wrst");
    reset = 1'b0;
    @(negedge clk);
    kind = 3'b101; op = OP_R; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2;
    valid_a = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("held_not_ready", 64'(rdy_a), 64'd0);
    end
    valid_a = 1'b0;
    chk_reset_a("post_hold");

    // Small memory: four words fit, the fifth overflows.
    pulse_start(1);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1, 0, 32'h00100093);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2, 1, 1, 32'h00200093);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1, 2, 32'h00300093);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4, 1, 3, 32'h00400093);
    @(posedge clk); #1;
    chk("b_full_count", 64'(cnt_b), 64'd4);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5, 0, 0, 32'd0);
    chk("b_ovf_err",  64'(err_b),  64'd1);
    chk("b_ovf_crst", 64'(crst_b), 64'd1);
    chk("b_ovf_we",   64'(we_b),   64'd0);

    pulse_start(1);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd1, 1, 0, 32'h00100093);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd2, 1, 1, 32'h00200093);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd3, 1, 2, 32'h00300093);
    send(1, 3'b000, OP_I, 3'b000, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4, 1, 3, 32'h00400093);
    send(1, 3'b111, 7'd0, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'd0, 0, 0, 32'd0);
    chk("b_full_done",  64'(done_b), 64'd1);
    chk("b_full_cnt4",  64'(cnt_b),  64'd4);
    chk("b_full_crst",  64'(crst_b), 64'd0);

    repeat (4) @(negedge clk);
    chk("a_writes_drained", 64'(qa.size()), 64'd0);
    chk("b_writes_drained", 64'(qb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
